// File: rtl/led_pattern_ctrl.sv
// Front-panel LED pattern controller.
// Buttons are synchronised, debounced and edge-detected; the resulting press
// pulses drive a mode FSM (IDLE/TOGGLE/COUNT/SHIFT) and a 4-step rate select.
// The selected pattern advances on a prescaled tick.
// Optional build macro PATTERN_PAUSE_EN adds btnL, which toggles a pause flag.

// One button lane: 2-flop synchroniser, debouncer, rising-edge press pulse.
module led_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          deb_q;
  logic          deb_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchroniser; sync_q[1] is the clean level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

  // Debounce: the new level must differ from the debounced level for
  // DEBOUNCE_CYCLES consecutive samples before it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else if (sync_q[1] == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      deb_q <= sync_q[1];
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered one-cycle pulse on a debounced 0->1; releases are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_dly_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      deb_dly_q <= deb_q;
      press_q   <= deb_q & ~deb_dly_q;
    end
  end

  assign press_o = press_q;
endmodule

module led_pattern_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
`ifdef PATTERN_PAUSE_EN
  input  logic       btnL,
`endif
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [1:0] rate
);
  localparam int PW = $clog2(TICK_CYCLES);

`ifdef PATTERN_PAUSE_EN
  localparam int NUM_BTN = 4;
`else
  localparam int NUM_BTN = 3;
`endif

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_TOGGLE = 2'd1,
    M_COUNT  = 2'd2,
    M_SHIFT  = 2'd3
  } mode_e;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;

  mode_e         mode_q;
  mode_e         mode_d;
  logic [7:0]    led_q;
  logic [7:0]    led_step;
  logic [7:0]    led_entry;
  logic [1:0]    rate_q;
  logic [1:0]    rate_d;
  logic [PW-1:0] pre_q;
  logic [PW-1:0] last_cnt;
  logic          mode_adv;
  logic          rate_up;
  logic          rate_dn;
  logic          rate_chg;
  logic          tick;
  logic          pause_hold;

  // Bit order: 0=C (mode), 1=U (faster), 2=D (slower), 3=L (pause).
`ifdef PATTERN_PAUSE_EN
  assign raw = {btnL, btnD, btnU, btnC};
`else
  assign raw = {btnD, btnU, btnC};
`endif

  led_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTN-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (raw),
    .press_o (press)
  );

`ifdef PATTERN_PAUSE_EN
  logic paused_q;

  // Pause flag toggles per btnL press; any mode change forces it clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        paused_q <= 1'b0;
    else if (mode_adv) paused_q <= 1'b0;
    else if (press[3]) paused_q <= ~paused_q;
  end

  assign pause_hold = paused_q;
`else
  assign pause_hold = 1'b0;
`endif

  // Next mode/rate, entry value, tick detect and per-mode step value.
  always_comb begin
    mode_adv  = press[0];
    mode_d    = mode_e'(mode_q + 2'd1);
    led_entry = (mode_d == M_SHIFT) ? 8'h01 : 8'h00;
    // Opposite presses in the same cycle cancel.
    rate_up   = press[1] & ~press[2];
    rate_dn   = press[2] & ~press[1];
    rate_d    = rate_q;
    if (rate_up && rate_q != 2'd3)      rate_d = rate_q + 2'd1;
    else if (rate_dn && rate_q != 2'd0) rate_d = rate_q - 2'd1;
    rate_chg  = (rate_d != rate_q);
    last_cnt  = PW'((TICK_CYCLES >> rate_q) - 1);
    tick      = (pre_q == last_cnt);
    case (mode_q)
      M_TOGGLE: led_step = ~led_q;
      M_COUNT:  led_step = led_q + 8'd1;
      M_SHIFT:  led_step = {led_q[6:0], led_q[7]};
      default:  led_step = 8'h00;
    endcase
  end

  // Mode FSM, rate, prescaler and LED register. Mode change beats rate
  // change beats tick; a discarded tick still restarts the prescaler at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_IDLE;
      led_q  <= 8'h00;
      rate_q <= 2'd0;
      pre_q  <= '0;
    end else if (mode_adv) begin
      mode_q <= mode_d;
      led_q  <= led_entry;
      rate_q <= rate_d;
      pre_q  <= '0;
    end else if (rate_chg) begin
      rate_q <= rate_d;
      pre_q  <= '0;
    end else if (!pause_hold) begin
      if (tick) begin
        pre_q <= '0;
        led_q <= led_step;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign rate = rate_q;
endmodule
